// File: rtl/inst_mem_loader.sv
// Instruction-memory loader: packs a big-endian byte stream into 32-bit words and
// writes them to consecutive word addresses while holding the CPU off.
module inst_mem_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  cpu_hold
);

  localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE       = {{ADDR_WIDTH{1'b0}}, 1'b1};

  // IDLE: wait for start | LOAD: take bytes | LAST_WRITE: final word pulse | DONE: CPU released
  typedef enum logic [1:0] {IDLE, LOAD, LAST_WRITE, DONE} state_t;

  state_t                state_q, state_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [31:0]           asm_q, asm_d;
  logic [ADDR_WIDTH:0]   word_idx_q, word_idx_d;
  logic [ADDR_WIDTH:0]   words_total_q, words_total_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic [ADDR_WIDTH:0]   wc_sat;

  assign wc_sat = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      byte_cnt_q    <= '0;
      asm_q         <= '0;
      word_idx_q    <= '0;
      words_total_q <= '0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      asm_q         <= asm_d;
      word_idx_q    <= word_idx_d;
      words_total_q <= words_total_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    asm_d         = asm_q;
    word_idx_d    = word_idx_q;
    words_total_d = words_total_q;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          byte_cnt_d    = '0;
          word_idx_d    = '0;
          words_total_d = wc_sat;
          state_d       = (wc_sat == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (in_valid) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: asm_d[31:24] = in_data;
            2'd1: asm_d[23:16] = in_data;
            2'd2: asm_d[15:8]  = in_data;
            default: begin
              // The fourth byte bypasses asm_q so the word is written the very next cycle.
              mem_we_d    = 1'b1;
              mem_addr_d  = word_idx_q[ADDR_WIDTH-1:0];
              mem_wdata_d = {asm_q[31:8], in_data};
              word_idx_d  = word_idx_q + ONE;
              if (word_idx_q == words_total_q - ONE) state_d = LAST_WRITE;
            end
          endcase
        end
      end
      LAST_WRITE: state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == LOAD);
  assign busy      = (state_q == LOAD) || (state_q == LAST_WRITE);
  assign done      = (state_q == DONE);
  assign cpu_hold  = (state_q != DONE);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Randomized self-checking bench for inst_mem_loader: each session's expected writes
// are derived directly from the byte list and the saturated word count.
module tb_inst_mem_loader;

  localparam int AW   = 10;
  localparam int MAXW = 1 << AW;

  typedef logic [AW:0]   wc_t;
  typedef logic [AW-1:0] addr_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [AW:0]   word_count;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy;
  logic          done;
  logic          cpu_hold;

  int checks   = 0;
  int failures = 0;

  logic [7:0]       src_q[$];
  logic [AW+31:0]   got_q[$];

  inst_mem_loader #(.ADDR_WIDTH(AW)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .word_count (word_count),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .cpu_hold   (cpu_hold)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (mem_we === 1'b1) got_q.push_back({mem_addr, mem_wdata});
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_session(input int wc, input int gap_min, input int gap_max, input bit mid_start);
    int n, sent, cyc, ready_low, limit;
    logic [31:0] w;
    n = (wc > MAXW) ? MAXW : wc;
    while (src_q.size() < 4 * n) src_q.push_back(8'($urandom_range(0, 255)));
    got_q.delete();
    start = 1'b1;
    word_count = wc_t'(wc);
    tick();
    start = 1'b0;
    if (n == 0) begin
      chk("zero_done", 64'(done), 64'd1);
      chk("zero_hold", 64'(cpu_hold), 64'd0);
      chk("zero_busy", 64'(busy), 64'd0);
      tick();
      tick();
      chk("zero_nowrite", 64'(got_q.size()), 64'd0);
      chk("zero_stay_done", 64'(done), 64'd1);
      src_q.delete();
      return;
    end
    chk("start_hold", 64'(cpu_hold), 64'd1);
    chk("start_busy", 64'(busy), 64'd1);
    sent = 0;
    cyc = 0;
    ready_low = 0;
    limit = 4 * n * (gap_max + 2) + 100;
    while (sent < 4 * n) begin
      if (cyc > limit) begin
        chk("timeout_bytes", 64'(sent), 64'(4 * n));
        break;
      end
      if (sent > 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(gap_max, gap_min)) begin
          if (in_ready !== 1'b1) ready_low++;
          tick();
          cyc++;
        end
      end
      if (mid_start && sent == 5) begin
        start = 1'b1;
        word_count = wc_t'(3);
      end
      in_data = src_q[sent];
      in_valid = 1'b1;
      if (in_ready === 1'b1) sent++;
      else ready_low++;
      tick();
      cyc++;
      start = 1'b0;
    end
    in_valid = 1'b0;
    chk("ready_in_load", 64'(ready_low), 64'd0);
    chk("lastwr_we", 64'(mem_we), 64'd1);
    chk("lastwr_busy", 64'(busy), 64'd1);
    chk("lastwr_done", 64'(done), 64'd0);
    chk("lastwr_hold", 64'(cpu_hold), 64'd1);
    tick();
    chk("end_done", 64'(done), 64'd1);
    chk("end_hold", 64'(cpu_hold), 64'd0);
    chk("end_busy", 64'(busy), 64'd0);
    chk("end_ready", 64'(in_ready), 64'd0);
    chk("wr_count", 64'(got_q.size()), 64'(n));
    for (int i = 0; i < n && i < got_q.size(); i++) begin
      w = {src_q[4*i], src_q[4*i+1], src_q[4*i+2], src_q[4*i+3]};
      chk("wr_entry", 64'(got_q[i]), 64'({addr_t'(i), w}));
    end
    w = {src_q[4*n-4], src_q[4*n-3], src_q[4*n-2], src_q[4*n-1]};
    tick();
    chk("hold_addr", 64'(mem_addr), 64'(addr_t'(n - 1)));
    chk("hold_data", 64'(mem_wdata), 64'(w));
    chk("stay_done", 64'(done), 64'd1);
    src_q.delete();
  endtask

  initial begin
    logic [31:0] w0;
    reset = 1'b1;
    start = 1'b0;
    word_count = '0;
    in_data = '0;
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_we", 64'(mem_we), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hold", 64'(cpu_hold), 64'd1);

    // Zero-length session from IDLE
    run_session(0, 0, 0, 1'b0);

    src_q = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
    run_session(2, 0, 0, 1'b0);

    src_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_session(1, 3, 3, 1'b0);

    run_session(3, 0, 2, 1'b1);
    run_session(1, 0, 1, 1'b0);

    // Reset part-way through the second word, colliding with start and a valid byte
    src_q.delete();
    for (int i = 0; i < 8; i++) src_q.push_back(8'($urandom_range(0, 255)));
    w0 = {src_q[0], src_q[1], src_q[2], src_q[3]};
    got_q.delete();
    start = 1'b1;
    word_count = wc_t'(2);
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_data = src_q[i];
      in_valid = 1'b1;
      tick();
    end
    in_data = src_q[6];
    in_valid = 1'b1;
    start = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    chk("mid_rst_ready", 64'(in_ready), 64'd0);
    chk("mid_rst_we", 64'(mem_we), 64'd0);
    chk("mid_rst_addr", 64'(mem_addr), 64'd0);
    chk("mid_rst_wdata", 64'(mem_wdata), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_hold", 64'(cpu_hold), 64'd1);
    tick();
    tick();
    chk("mid_rst_idle", 64'(busy), 64'd0);
    chk("mid_rst_wrcount", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) chk("mid_rst_word0", 64'(got_q[0]), 64'({addr_t'(0), w0}));
    src_q.delete();
    run_session(1, 0, 2, 1'b0);

    for (int s = 0; s < 8; s++) begin
      int g;
      g = $urandom_range(0, 3);
      run_session($urandom_range(1, 6), 0, g, 1'($urandom_range(0, 1)));
    end

    // Zero-length start from DONE stays in DONE without writing
    run_session(0, 0, 0, 1'b0);

    run_session(MAXW + 1, 0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_mem_loader.md
INST_MEM_LOADER -- requirements
Module: inst_mem_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, instruction-memory word-address width matching the 10-bit PC.
REQ-002 SHALL have port clock  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  single-cycle pulse that begins a load session.
REQ-005 SHALL have port word_count  input  ADDR_WIDTH+1  number of 32-bit instructions to load, sampled when start is accepted.
REQ-006 SHALL have port in_data  input  8  byte stream payload.
REQ-007 SHALL have port in_valid  input  1  in_data holds a valid byte.
REQ-008 SHALL have port in_ready  output  1  loader accepts a byte this cycle.
REQ-009 SHALL have port mem_we  output  1  instruction-memory write enable, one-cycle pulse per word.
REQ-010 SHALL have port mem_addr  output  ADDR_WIDTH  instruction-memory word address.
REQ-011 SHALL have port mem_wdata  output  32  instruction word to write.
REQ-012 SHALL have port busy  output  1  high while a session is in progress.
REQ-013 SHALL have port done  output  1  high when the last requested word has been written.
REQ-014 SHALL have port cpu_hold  output  1  holds the processor PC/register writes while high.

Function
REQ-015 SHALL implement states IDLE, LOAD, LAST_WRITE, DONE; reset enters IDLE.
REQ-016 IDLE: start=1 with word_count>0 -> LOAD; start=1 with word_count=0 -> DONE next cycle, no mem_we.
REQ-017 word_count above 2**ADDR_WIDTH SHALL saturate to 2**ADDR_WIDTH.
REQ-018 A byte SHALL be accepted only in a cycle where in_valid=1 and in_ready=1; in_ready=1 exactly in LOAD.
REQ-019 Bytes SHALL be assembled big-endian: 1st byte -> bits 31:24, 2nd -> 23:16, 3rd -> 15:8, 4th -> 7:0.
REQ-020 A 2-bit byte counter SHALL wrap 3 -> 0 on each 4th accepted byte.
REQ-021 On the cycle after a 4th byte is accepted, mem_we SHALL be 1 for exactly one cycle with mem_wdata = assembled word and mem_addr = word index.
REQ-022 Word index SHALL start at 0 per session and increment by 1 after each mem_we; at 2**ADDR_WIDTH words the session ends, no wrap.
REQ-023 Acceptance of the final byte of the final word SHALL move LOAD -> LAST_WRITE; mem_we pulses in LAST_WRITE; next cycle -> DONE.
REQ-024 in_valid gaps SHALL stall assembly without losing partial-word bytes.
REQ-025 busy SHALL be 1 in LOAD and LAST_WRITE, else 0; done SHALL be 1 only in DONE.
REQ-026 cpu_hold SHALL be 1 in IDLE, LOAD, LAST_WRITE and 0 only in DONE, so the processor first fetches one cycle after the final write completes.
REQ-027 start in LOAD or LAST_WRITE SHALL be ignored; start in DONE SHALL begin a new session (DONE -> LOAD or DONE, per REQ-016), cpu_hold returning to 1 the next cycle.
REQ-028 mem_addr and mem_wdata SHALL hold their last values when mem_we=0.

Reset
REQ-029 reset=1 SHALL, at the next rising edge, force IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, cpu_hold=1.
REQ-030 reset during LOAD or LAST_WRITE SHALL discard the partial word and suppress any pending mem_we.
REQ-031 reset SHALL take priority over start and byte acceptance in the same cycle.

Verification
REQ-032 start, word_count=2, bytes 20 08 00 05 8C 09 00 04 back-to-back -> mem_we at addr 0 data 0x20080005, then addr 1 data 0x8C090004; done=1, cpu_hold=0 two cycles after the 8th byte.
REQ-033 word_count=1, bytes with in_valid low 3 cycles between each -> single write 0xAABBCCDD at addr 0, no extra mem_we, in_ready=1 throughout LOAD.
REQ-034 start with word_count=0 -> DONE next cycle, mem_we never asserted, cpu_hold 1 -> 0.
REQ-035 reset after 6 of 8 bytes -> only addr 0 written, state IDLE, cpu_hold=1; new start with word_count=1 writes addr 0 again.
REQ-036 start pulsed mid-LOAD -> ignored, word index continues; start in DONE with word_count=1 -> cpu_hold=1 next cycle, rewrite addr 0.
REQ-037 word_count=2**ADDR_WIDTH+1 -> saturated; exactly 1024 writes, last at addr 1023, then DONE.
